hack_cpu_ctrl: RTL and testbench

//   Hack CPU control/datapath shell; the initiator that drives the external Hack ALU.

---
 rtl/hack_pkg.sv | 34 +++
 rtl/hack_jump_unit.sv | 12 +
 rtl/hack_cpu_ctrl.sv | 130 +++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and instruction field positions for the Hack CPU control shell.
// Field indices assume the 16-bit Hack instruction encoding.
package hack_pkg;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      MEM_WAIT = 2'd1,
      EXEC     = 2'd2
   } cpu_state_e;

   localparam int IR_CBIT = 15;
   localparam int IR_ABIT = 12;
   localparam int IR_C_HI = 11;
   localparam int IR_C_LO = 6;
   localparam int IR_D_A  = 5;
   localparam int IR_D_D  = 4;
   localparam int IR_D_M  = 3;
   localparam int IR_J_HI = 2;
   localparam int IR_J_LO = 0;

   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

   function automatic alu_ctrl_t decode_alu_ctrl(input logic [5:0] c);
      return alu_ctrl_t'(c);
   endfunction

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational jump resolution from the j1/j2/j3 bits and ALU flags.
// j1 = jump if negative, j2 = jump if zero, j3 = jump if strictly positive.
module hack_jump_unit (
   input  logic [2:0] j,
   input  logic       zr,
   input  logic       ng,
   output logic       jump
);

   assign jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/datapath shell: fetches over valid/ready, holds A/D/PC and drives
// the external ALU; commits results and resolves jumps in a single EXEC cycle.
module hack_cpu_ctrl
   import hack_pkg::*;
#(
   parameter int              WIDTH    = 16,
   parameter int              PC_W     = 15,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic [PC_W-1:0]  pc,
   output logic             mem_rd,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] inM,
   output logic             writeM,
   output logic [PC_W-1:0]  addressM,
   output logic [WIDTH-1:0] outM,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic             alu_zx,
   output logic             alu_nx,
   output logic             alu_zy,
   output logic             alu_ny,
   output logic             alu_f,
   output logic             alu_no,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng
);

   cpu_state_e       state_q, state_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] inm_q, inm_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  pc_inc;
   logic             is_c;
   logic             jump;
   alu_ctrl_t        alu_ctrl;

   assign is_c   = ir_q[IR_CBIT];
   assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

   hack_jump_unit u_jump (
      .j    (ir_q[IR_J_HI:IR_J_LO]),
      .zr   (alu_zr),
      .ng   (alu_ng),
      .jump (jump)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ir_q    <= '0;
         a_q     <= '0;
         d_q     <= '0;
         inm_q   <= '0;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         d_q     <= d_d;
         inm_q   <= inm_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      a_d         = a_q;
      d_d         = d_q;
      inm_d       = inm_q;
      pc_d        = pc_q;
      instr_ready = 1'b0;
      mem_rd      = 1'b0;
      writeM      = 1'b0;
      case (state_q)
         FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = instr;
               state_d = (instr[IR_CBIT] && instr[IR_ABIT]) ? MEM_WAIT : EXEC;
            end
         end
         MEM_WAIT: begin
            mem_rd = 1'b1;
            if (mem_rvalid) begin
               inm_d   = inM;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            if (!is_c) begin
               a_d  = ir_q;
               pc_d = pc_inc;
            end else begin
               // a_q still holds A_old here, so the jump target and addressM see it.
               if (ir_q[IR_D_A]) a_d = alu_out;
               if (ir_q[IR_D_D]) d_d = alu_out;
               writeM = ir_q[IR_D_M];
               pc_d   = jump ? a_q[PC_W-1:0] : pc_inc;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   assign alu_ctrl = decode_alu_ctrl(ir_q[IR_C_HI:IR_C_LO]);
   assign alu_zx   = alu_ctrl.zx;
   assign alu_nx   = alu_ctrl.nx;
   assign alu_zy   = alu_ctrl.zy;
   assign alu_ny   = alu_ctrl.ny;
   assign alu_f    = alu_ctrl.f;
   assign alu_no   = alu_ctrl.no;

   assign alu_x    = d_q;
   assign alu_y    = ir_q[IR_ABIT] ? inm_q : a_q;
   assign pc       = pc_q;
   assign addressM = a_q[PC_W-1:0];
   assign outM     = alu_out;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboarded bench for hack_cpu_ctrl: a behavioural Hack CPU model predicts writes and
// architectural state; monitors compare as the DUT completes instructions and writes.
module tb_hack_cpu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [14:0] pc;
   logic        mem_rd;
   logic        mem_rvalid;
   logic [15:0] inM;
   logic        writeM;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic [15:0] alu_x, alu_y;
   logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
   logic [15:0] alu_out;
   logic        alu_zr, alu_ng;

   always #5 clk = ~clk;

   hack_cpu_ctrl #(.WIDTH(16), .PC_W(15), .RESET_PC(15'd0)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .pc(pc), .mem_rd(mem_rd), .mem_rvalid(mem_rvalid),
      .inM(inM), .writeM(writeM), .addressM(addressM), .outM(outM),
      .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx),
      .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
   );

   // Hack ALU as defined by its truth table: zero/negate each input, add or and, negate output.
   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
      logic [15:0] xx, yy, o;
      xx = c[5] ? 16'd0 : x;
      if (c[4]) xx = ~xx;
      yy = c[3] ? 16'd0 : y;
      if (c[2]) yy = ~yy;
      o = c[1] ? (xx + yy) : (xx & yy);
      if (c[0]) o = ~o;
      return o;
   endfunction

   assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
   assign alu_zr  = (alu_out == 16'd0);
   assign alu_ng  = alu_out[15];

   typedef struct { logic [14:0] pc; logic [15:0] a; logic [15:0] d; logic [5:0] c; } done_t;
   typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;
   typedef struct { logic [14:0] addr; logic [15:0] data; int delay; } rd_t;

   done_t done_q[$];
   wr_t   wr_q[$];
   rd_t   rd_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   bit pending  = 0;
   bit mem_en   = 1;
   int mem_cnt  = 0;

   logic [15:0] m_a, m_d;
   logic [14:0] m_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic end_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Architectural model: one whole instruction at a time, expectations queued in order.
   task automatic model_step(input logic [15:0] ins, input logic [15:0] md, input int mdel);
      logic [15:0] y, res;
      logic        zr, ng, jmp;
      logic [14:0] a_old;
      a_old = m_a[14:0];
      if (!ins[15]) begin
         m_a  = ins;
         m_pc = m_pc + 15'd1;
      end else begin
         if (ins[12]) rd_q.push_back('{addr: a_old, data: md, delay: mdel});
         y   = ins[12] ? md : m_a;
         res = hack_alu(m_d, y, ins[11:6]);
         zr  = (res == 16'd0);
         ng  = res[15];
         jmp = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !zr && !ng);
         if (ins[3]) wr_q.push_back('{addr: a_old, data: res});
         m_pc = jmp ? a_old : m_pc + 15'd1;
         if (ins[5]) m_a = res;
         if (ins[4]) m_d = res;
      end
      done_q.push_back('{pc: m_pc, a: m_a, d: m_d, c: ins[11:6]});
   endtask

   task automatic drive(input logic [15:0] ins);
      int waited;
      @(posedge clk); #1;
      instr       = ins;
      instr_valid = 1'b1;
      waited      = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!instr_ready && waited < 200);
      if (!instr_ready) begin
         check("fetch_timeout", {31'd0, instr_ready}, 32'd1);
         end_test();
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
   endtask

   task automatic issue(input logic [15:0] ins, input logic [15:0] md, input int mdel);
      model_step(ins, md, mdel);
      drive(ins);
   endtask

   // Memory responder: answers each read after its chosen delay with the queued data.
   initial begin
      mem_rvalid = 1'b0;
      inM        = 16'd0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (!rst_n) begin
            mem_cnt = 0;
         end else if (mem_en && mem_rd) begin
            if (rd_q.size() == 0) begin
               check("unexpected_mem_rd", {31'd0, mem_rd}, 32'd0);
            end else begin
               if (mem_cnt == 0) check("mem_rd_addr", {17'd0, addressM}, {17'd0, rd_q[0].addr});
               if (mem_cnt >= rd_q[0].delay) begin
                  inM        = rd_q[0].data;
                  mem_rvalid = 1'b1;
                  void'(rd_q.pop_front());
                  mem_cnt = 0;
               end else begin
                  mem_cnt++;
               end
            end
         end
      end
   end

   // Output monitor: write strobes and instruction completion.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 0;
      end else begin
         if (writeM) begin
            if (wr_q.size() == 0) begin
               check("spurious_writeM", {31'd0, writeM}, 32'd0);
            end else begin
               check("write_addr", {17'd0, addressM}, {17'd0, wr_q[0].addr});
               check("write_data", {16'd0, outM}, {16'd0, wr_q[0].data});
               void'(wr_q.pop_front());
            end
         end
         if (pending && instr_ready) begin
            pending = 0;
            if (done_q.size() == 0) begin
               check("unexpected_completion", 32'd1, 32'd0);
            end else begin
               check("pc", {17'd0, pc}, {17'd0, done_q[0].pc});
               check("A", {17'd0, addressM}, {17'd0, done_q[0].a[14:0]});
               check("D", {16'd0, alu_x}, {16'd0, done_q[0].d});
               check("alu_ctrl", {26'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
                     {26'd0, done_q[0].c});
               void'(done_q.pop_front());
            end
         end
         if (instr_valid && instr_ready) pending = 1;
      end
   end

   initial begin
      logic [15:0] ins;
      int          waited;
      rst_n       = 1'b0;
      instr       = 16'd0;
      instr_valid = 1'b0;
      m_a         = 16'd0;
      m_d         = 16'd0;
      m_pc        = 15'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_writeM", {31'd0, writeM}, 32'd0);
      check("rst_pc", {17'd0, pc}, 32'd0);

      // Abort an instruction stalled in MEM_WAIT with reset.
      issue(16'h0007, 16'd0, 0);
      issue(16'hEC10, 16'd0, 0);
      issue(16'h0123, 16'd0, 0);
      mem_en = 0;
      drive(16'hFC20);
      repeat (3) @(negedge clk);
      check("stall_mem_rd", {31'd0, mem_rd}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("abort_instr_ready", {31'd0, instr_ready}, 32'd1);
      check("abort_pc", {17'd0, pc}, 32'd0);
      check("abort_A", {17'd0, addressM}, 32'd0);
      check("abort_D", {16'd0, alu_x}, 32'd0);
      m_a  = 16'd0;
      m_d  = 16'd0;
      m_pc = 15'd0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      mem_en = 1;

      // Directed: D=A, M=D+1, A=M with slow memory, JEQ/JGT, pc wrap, idle fetch.
      issue(16'h0005, 16'd0, 0);
      issue(16'hEC10, 16'd0, 0);
      issue(16'h0007, 16'd0, 0);
      issue(16'hEC10, 16'd0, 0);
      issue(16'd100, 16'd0, 0);
      issue(16'hE7C8, 16'd0, 0);
      issue(16'hFC20, 16'hBEEF, 3);
      issue(16'hEA90, 16'd0, 0);
      issue(16'h0020, 16'd0, 0);
      issue(16'hEA82, 16'd0, 0);
      issue(16'hEA81, 16'd0, 0);
      issue(16'h7FFF, 16'd0, 0);
      issue(16'hEA87, 16'd0, 0);
      issue(16'h0001, 16'd0, 0);
      repeat (5) @(posedge clk);
      issue(16'h8000 | 16'hEA8F, 16'd0, 0);

      // Randomized instruction stream with random memory latency and idle gaps.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0)
            ins = {1'b0, 15'($urandom)};
         else
            ins = {1'b1, 15'($urandom)};
         issue(ins, 16'($urandom), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      end

      waited = 0;
      while ((done_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("drain_done_q", done_q.size(), 32'd0);
      check("drain_wr_q", wr_q.size(), 32'd0);
      end_test();
   end

endmodule
